// File: rtl/perceptron_load_ctrl.sv
// perceptron_load_ctrl
// Sequencer for the perceptron's serial-to-parallel input buffer. Accepts a
// valid/ready stream of samples, shifts each accepted word into the buffer,
// fires a one-cycle MAC start after a full frame, then holds the stream off
// until the MAC reports done. Flags frame-length violations on err_len.

module perceptron_load_ctrl #(
    parameter int DATA_W = 32,
    parameter int N_IN   = 10,
    parameter int CNT_W  = 4,
    parameter int FCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    input  logic              abort,
    output logic              sh_en,
    output logic [DATA_W-1:0] sh_data,
    output logic              mac_start,
    input  logic              mac_done,
    output logic              busy,
    output logic              err_len,
    output logic [FCNT_W-1:0] frame_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FIRE = 2'd2,
        WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_IN - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             accept;
    logic             start_nxt;
    logic             err_nxt;
    logic             done_nxt;

    // Ready depends only on state and abort so upstream never sees a
    // combinational path from its own valid back to ready.
    assign s_ready = ((state == IDLE) || (state == LOAD)) && !abort;
    assign accept  = s_valid && s_ready;
    assign busy    = (state != IDLE);

    // Next-state and pulse decode; abort overrides every state.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // otherwise an unassigned path would infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        start_nxt = 1'b0;
        err_nxt   = 1'b0;
        done_nxt  = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    // In IDLE cnt is always 0, and N_IN>=2 keeps word 0 from
                    // ever being the final word, so both states share this.
                    if (accept) begin
                        if (cnt == LAST_IDX) begin
                            state_nxt = FIRE;
                            cnt_nxt   = cnt + 1'b1;
                            err_nxt   = !s_last;
                        end else if (s_last) begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                            err_nxt   = 1'b1;
                        end else begin
                            state_nxt = LOAD;
                            cnt_nxt   = cnt + 1'b1;
                        end
                    end
                end
                FIRE: begin
                    start_nxt = 1'b1;
                    state_nxt = WAIT;
                end
                WAIT: begin
                    if (mac_done) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        done_nxt  = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State, counters and registered outputs; all cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sh_en     <= 1'b0;
            sh_data   <= '0;
            mac_start <= 1'b0;
            err_len   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            sh_en     <= accept;
            mac_start <= start_nxt;
            err_len   <= err_nxt;
            if (accept) begin
                sh_data <= s_data;
            end
            if (done_nxt) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_perceptron_load_ctrl.sv
// tb_perceptron_load_ctrl
// Scoreboard bench: the driver pushes expected shifted words and expected
// err_len / mac_start events as it issues frames; a negedge monitor pops and
// compares whenever the DUT raises sh_en, err_len or mac_start.

module tb_perceptron_load_ctrl;

    localparam int DATA_W = 32;
    localparam int N_IN   = 10;
    localparam int CNT_W  = 4;
    localparam int FCNT_W = 16;

    typedef enum int { EV_ERR, EV_START } ev_t;

    logic              clk;
    logic              rst;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              s_ready;
    logic              abort;
    logic              sh_en;
    logic [DATA_W-1:0] sh_data;
    logic              mac_start;
    logic              mac_done;
    logic              busy;
    logic              err_len;
    logic [FCNT_W-1:0] frame_cnt;

    int total = 0;
    int bad   = 0;
    int model_frames = 0;
    int cyc = 0;
    int last_sh_cyc = -100;

    logic [DATA_W-1:0] exp_data[$];
    ev_t               exp_ev[$];

    perceptron_load_ctrl #(
        .DATA_W(DATA_W), .N_IN(N_IN), .CNT_W(CNT_W), .FCNT_W(FCNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .abort(abort),
        .sh_en(sh_en), .sh_data(sh_data),
        .mac_start(mac_start), .mac_done(mac_done),
        .busy(busy), .err_len(err_len), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an output event.
    always @(negedge clk) begin
        if (!rst) begin
            cyc++;
            if (sh_en) begin
                if (exp_data.size() == 0) begin
                    check("sh_en_unexpected", sh_en, 0);
                end else begin
                    check("sh_data", sh_data, exp_data.pop_front());
                end
                last_sh_cyc = cyc;
            end
            if (err_len) begin
                if (exp_ev.size() == 0 || exp_ev[0] != EV_ERR) begin
                    check("err_len_unexpected", err_len, 0);
                end else begin
                    void'(exp_ev.pop_front());
                    check("err_len_with_last_word", cyc - last_sh_cyc, 0);
                end
            end
            if (mac_start) begin
                if (exp_ev.size() == 0 || exp_ev[0] != EV_START) begin
                    check("mac_start_unexpected", mac_start, 0);
                end else begin
                    void'(exp_ev.pop_front());
                    check("mac_start_delay", cyc - last_sh_cyc, 1);
                end
            end
        end
    end

    // Offer one word after gap idle cycles; in IDLE/LOAD it must be taken at once.
    task automatic send_word(input logic [DATA_W-1:0] d, input bit last, input int gap);
        repeat (gap) begin
            s_valid  = 1'b0;
            mac_done = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        mac_done = 1'b0;
        s_valid  = 1'b1;
        s_data   = d;
        s_last   = last;
        exp_data.push_back(d);
        #1 check("s_ready_load", s_ready, 1);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = $urandom;
    endtask

    // One frame of len words. post: 0 = mac_done after dly WAIT cycles,
    // 1 = abort in FIRE, 2 = abort together with mac_done in WAIT.
    task automatic send_frame(input int len, input bit mark_last, input int min_gap,
                              input int max_gap, input int post, input int dly,
                              input bit fixed_data);
        for (int i = 0; i < len; i++) begin
            logic [DATA_W-1:0] d;
            bit last;
            d    = fixed_data ? DATA_W'(i + 1) : DATA_W'($urandom);
            last = mark_last && (i == len - 1);
            if (i == len - 1) begin
                if (len < N_IN) begin
                    exp_ev.push_back(EV_ERR);
                end else begin
                    if (!mark_last) exp_ev.push_back(EV_ERR);
                    if (post != 1) exp_ev.push_back(EV_START);
                end
            end
            send_word(d, last, $urandom_range(min_gap, max_gap));
        end
        if (len < N_IN) begin
            #1 check("short_frame_idle", busy, 0);
            return;
        end
        // FIRE cycle: a pending word must not be accepted.
        s_valid  = 1'b1;
        s_data   = $urandom;
        mac_done = 1'($urandom_range(0, 1));
        #1 check("s_ready_fire", s_ready, 0);
        check("busy_fire", busy, 1);
        if (post == 1) begin
            mac_done = 1'b0;
            abort    = 1'b1;
            @(negedge clk);
            abort   = 1'b0;
            s_valid = 1'b0;
        end else begin
            @(negedge clk);
            for (int k = 0; k <= dly; k++) begin
                mac_done = (k == dly);
                abort    = (post == 2) && (k == dly);
                #1 check("s_ready_wait", s_ready, 0);
                @(negedge clk);
            end
            mac_done = 1'b0;
            abort    = 1'b0;
            s_valid  = 1'b0;
            if (post == 0) model_frames++;
        end
        #1 check("busy_after_frame", busy, 0);
        check("s_ready_after_frame", s_ready, 1);
        check("frame_cnt", frame_cnt, FCNT_W'(model_frames));
    endtask

    // Load n words then abort while a word is offered.
    task automatic abort_load(input int n);
        for (int i = 0; i < n; i++) send_word($urandom, 1'b0, $urandom_range(0, 1));
        s_valid = 1'b1;
        s_data  = $urandom;
        abort   = 1'b1;
        #1 check("s_ready_abort", s_ready, 0);
        @(negedge clk);
        abort   = 1'b0;
        s_valid = 1'b0;
        #1 check("busy_after_abort", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        abort = 1'b0; mac_done = 1'b0;
        #3;
        check("rst_sh_en", sh_en, 0);
        check("rst_sh_data", sh_data, 0);
        check("rst_mac_start", mac_start, 0);
        check("rst_err_len", err_len, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Nominal frame 0x1..0xA, mac_done two cycles into WAIT.
        send_frame(N_IN, 1'b1, 0, 0, 0, 2, 1'b1);
        // Throttled: one idle cycle before every word.
        send_frame(N_IN, 1'b1, 1, 1, 0, 1, 1'b0);
        // Short frame (s_last on word 4), then a full frame.
        send_frame(4, 1'b1, 0, 0, 0, 0, 1'b0);
        send_frame(N_IN, 1'b1, 0, 1, 0, 0, 1'b0);
        // Missing last: error flagged, frame still fires.
        send_frame(N_IN, 1'b0, 0, 0, 0, 1, 1'b0);
        // Abort in WAIT with simultaneous mac_done.
        send_frame(N_IN, 1'b1, 0, 0, 2, 1, 1'b0);
        // Abort in FIRE and mid-load, each followed by a clean frame.
        send_frame(N_IN, 1'b1, 0, 0, 1, 0, 1'b0);
        abort_load(5);
        send_frame(N_IN, 1'b1, 0, 0, 0, 0, 1'b0);

        // Async reset mid-load with cnt=5 and frame_cnt nonzero.
        for (int i = 0; i < 5; i++) send_word($urandom, 1'b0, 0);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_sh_en", sh_en, 0);
        check("rst_mid_sh_data", sh_data, 0);
        check("rst_mid_mac_start", mac_start, 0);
        check("rst_mid_err_len", err_len, 0);
        check("rst_mid_frame_cnt", frame_cnt, 0);
        check("rst_mid_busy", busy, 0);
        model_frames = 0;
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst_mid_s_ready", s_ready, 1);
        @(negedge clk);
        send_frame(N_IN, 1'b1, 0, 0, 0, 0, 1'b0);

        // Randomized frames.
        for (int f = 0; f < 30; f++) begin
            int kind;
            kind = $urandom_range(0, 3);
            case (kind)
                0: send_frame(N_IN, 1'b1, 0, 2, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
                1: send_frame($urandom_range(1, N_IN - 1), 1'b1, 0, 2, 0, 0, 1'b0);
                2: send_frame(N_IN, 1'b0, 0, 2, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
                default: abort_load($urandom_range(0, N_IN - 1));
            endcase
        end

        repeat (3) @(negedge clk);
        check("exp_data_drained", exp_data.size(), 0);
        check("exp_ev_drained", exp_ev.size(), 0);
        check("frame_cnt_final", frame_cnt, FCNT_W'(model_frames));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
